// File: rtl/axi4_rd_arbiter_if.sv
// AXI4 read address/data channel bundle (AR + R) with a 13-bit {arlen, arsize, arburst} control field.
// Valid/ready: a beat or address transfers on a rising clock edge where valid && ready; the source holds valid and payload stable until then.
interface axi4_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [12:0]       arctl;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arid, arctl, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arctl, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one downstream AXI4 read port between the IFU (m0) and LSU (m1).
// One transaction in flight: IDLE accepts a request, ADDR issues it downstream, DATA routes R beats to the owner.
module axi4_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  axi4_rd_arbiter_if.slave        m0,
  axi4_rd_arbiter_if.slave        m1,
  axi4_rd_arbiter_if.master       s,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [12:0]       arctl_q, arctl_d;

  logic any_req;
  logic winner;
  logic rready_sel;

  // On a tie the master that did not win last time takes the grant.
  always_comb begin
    any_req = m0.arvalid | m1.arvalid;
    winner  = (m0.arvalid && m1.arvalid) ? ~last_grant_q : m1.arvalid;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    araddr_d     = araddr_q;
    arctl_d      = arctl_q;
    rready_sel   = 1'b0;
    m0.arready   = 1'b0;
    m1.arready   = 1'b0;
    s.arvalid    = 1'b0;
    m0.rvalid    = 1'b0;
    m0.rdata     = '0;
    m0.rresp     = '0;
    m0.rlast     = 1'b0;
    m1.rvalid    = 1'b0;
    m1.rdata     = '0;
    m1.rresp     = '0;
    m1.rlast     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          m0.arready   = ~winner;
          m1.arready   = winner;
          grant_d      = winner;
          last_grant_d = winner;
          araddr_d     = winner ? m1.araddr : m0.araddr;
          arctl_d      = winner ? m1.arctl : m0.arctl;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s.arvalid = 1'b1;
        if (s.arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (grant_q) begin
          m1.rvalid  = s.rvalid;
          m1.rdata   = s.rdata;
          m1.rresp   = s.rresp;
          m1.rlast   = s.rlast;
          rready_sel = m1.rready;
        end else begin
          m0.rvalid  = s.rvalid;
          m0.rdata   = s.rdata;
          m0.rresp   = s.rresp;
          m0.rlast   = s.rlast;
          rready_sel = m0.rready;
        end
        // A request pending on the final beat waits for the next IDLE cycle.
        if (s.rvalid && rready_sel && s.rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s.rready    = rready_sel;
  assign s.araddr    = araddr_q;
  assign s.arctl     = arctl_q;
  assign s.arid      = {{(ID_W-1){1'b0}}, grant_q};
  assign dbg_state_o = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      araddr_q     <= '0;
      arctl_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      araddr_q     <= araddr_d;
      arctl_q      <= arctl_d;
    end
  end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed plus randomized bench for axi4_rd_arbiter: the bench plays both masters and the downstream slave.
// Grant order comes from a round-robin model (last winner yields on a tie); routed beats go through a scoreboard queue.
module tb_axi4_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  axi4_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) m0_if ();
  axi4_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) m1_if ();
  axi4_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) s_if ();

  axi4_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clock       (clock),
    .reset       (reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .dbg_state_o (dbg_state)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // reference model state
  int            last_grant;
  bit            pend_v[2];
  logic [AW-1:0] pend_addr[2];
  logic [12:0]   pend_ctl[2];
  logic [12:0]   granted_ctl;
  logic [DW-1:0] data_q[$];
  logic [1:0]    resp_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] rand_ctl();
    logic [7:0] len;
    logic [2:0] sz;
    logic [1:0] bt;
    len = 8'($urandom_range(0, 3));
    sz  = 3'($urandom_range(0, 2));
    bt  = 2'($urandom_range(0, 2));
    return {len, sz, bt};
  endfunction

  function automatic logic get_rvalid(input int m);
    return (m == 1) ? m1_if.rvalid : m0_if.rvalid;
  endfunction
  function automatic logic [DW-1:0] get_rdata(input int m);
    return (m == 1) ? m1_if.rdata : m0_if.rdata;
  endfunction
  function automatic logic [1:0] get_rresp(input int m);
    return (m == 1) ? m1_if.rresp : m0_if.rresp;
  endfunction
  function automatic logic get_rlast(input int m);
    return (m == 1) ? m1_if.rlast : m0_if.rlast;
  endfunction

  task automatic drive_masters();
    m0_if.arvalid = pend_v[0];
    m0_if.araddr  = pend_addr[0];
    m0_if.arctl   = pend_ctl[0];
    m1_if.arvalid = pend_v[1];
    m1_if.araddr  = pend_addr[1];
    m1_if.arctl   = pend_ctl[1];
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] addr, input logic [12:0] ctl);
    pend_v[m]    = 1'b1;
    pend_addr[m] = addr;
    pend_ctl[m]  = ctl;
    drive_masters();
  endtask

  task automatic set_rready(input int m, input logic v);
    if (m == 1) m1_if.rready = v;
    else        m0_if.rready = v;
  endtask

  task automatic clear_inputs();
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    pend_addr[0] = '0; pend_addr[1] = '0;
    pend_ctl[0] = '0; pend_ctl[1] = '0;
    drive_masters();
    m0_if.arid = '0; m1_if.arid = '0;
    m0_if.rready = 1'b0; m1_if.rready = 1'b0;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;
    s_if.rresp = '0; s_if.rlast = 1'b0;
  endtask

  task automatic fill_beats(input int n);
    data_q.delete();
    resp_q.delete();
    for (int i = 0; i < n; i++) begin
      data_q.push_back(DW'($urandom));
      resp_q.push_back(2'($urandom_range(0, 3)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    exp_q.delete();
    last_grant = 1;
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_state", dbg_state, 0);
    check("rst_s_arvalid", s_if.arvalid, 0);
    check("rst_s_araddr", s_if.araddr, 0);
    check("rst_s_arctl", s_if.arctl, 0);
    check("rst_s_arid", s_if.arid, 0);
    check("rst_s_rready", s_if.rready, 0);
    check("rst_m0_arready", m0_if.arready, 0);
    check("rst_m1_arready", m1_if.arready, 0);
    check("rst_m0_rvalid", m0_if.rvalid, 0);
    check("rst_m1_rvalid", m1_if.rvalid, 0);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  // Address phase: model picks the winner, then the downstream AR is held for 'delay' extra cycles.
  task automatic ar_phase(input int delay, input bit post_rst, output int won);
    logic [AW-1:0] exp_addr;
    logic [12:0]   exp_ctl;
    if (pend_v[0] && pend_v[1]) won = 1 - last_grant;
    else                        won = pend_v[1] ? 1 : 0;
    exp_addr    = pend_addr[won];
    exp_ctl     = pend_ctl[won];
    granted_ctl = exp_ctl;
    @(negedge clock);
    check("idle_state", dbg_state, 0);
    check("m0_arready", m0_if.arready, (won == 0));
    check("m1_arready", m1_if.arready, (won == 1));
    check("idle_s_arvalid", s_if.arvalid, 0);
    check("idle_s_rready", s_if.rready, 0);
    check("idle_m0_rvalid", m0_if.rvalid, 0);
    check("idle_m1_rvalid", m1_if.rvalid, 0);
    if (post_rst) begin
      check("prst_s_araddr", s_if.araddr, 0);
      check("prst_s_arctl", s_if.arctl, 0);
      check("prst_s_arid", s_if.arid, 0);
      check("prst_m0_rdata", m0_if.rdata, 0);
      check("prst_m1_rdata", m1_if.rdata, 0);
      check("prst_m1_rlast", m1_if.rlast, 0);
    end
    @(posedge clock); #1;
    pend_v[won] = 1'b0;
    drive_masters();
    last_grant = won;
    for (int d = 0; d <= delay; d++) begin
      s_if.arready = (d == delay);
      s_if.rvalid  = 1'b1;
      s_if.rdata   = DW'($urandom);
      s_if.rlast   = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("addr_state", dbg_state, 1);
      check("s_arvalid", s_if.arvalid, 1);
      check("s_araddr", s_if.araddr, exp_addr);
      check("s_arctl", s_if.arctl, exp_ctl);
      check("s_arid", s_if.arid, won);
      check("addr_s_rready", s_if.rready, 0);
      check("addr_m0_rvalid", m0_if.rvalid, 0);
      check("addr_m1_rvalid", m1_if.rvalid, 0);
      check("addr_m0_arready", m0_if.arready, 0);
      check("addr_m1_arready", m1_if.arready, 0);
      @(posedge clock); #1;
    end
    s_if.arready = 1'b0;
    s_if.rvalid  = 1'b0;
    s_if.rlast   = 1'b0;
  endtask

  // Data phase: slave offers data_q beats; owner's rready follows a stall pattern or random.
  task automatic r_phase(input int owner, input int nbeats, input int stall_beat, input int stall_cyc,
                         input bit rand_rdy, input int req_last_m, input int abort_after);
    int   beat = 0;
    int   stalled = 0;
    int   gaps = 0;
    int   other;
    logic rdy;
    bit   lastb;
    other = 1 - owner;
    foreach (data_q[i]) exp_q.push_back(data_q[i]);
    while (beat < nbeats) begin
      if (rand_rdy && gaps < 3 && $urandom_range(0, 4) == 0) begin
        gaps++;
        rdy = 1'($urandom_range(0, 1));
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
        set_rready(owner, rdy);
        @(negedge clock);
        check("gap_state", dbg_state, 2);
        check("gap_own_rvalid", get_rvalid(owner), 0);
        check("gap_s_rready", s_if.rready, rdy);
        @(posedge clock); #1;
        continue;
      end
      lastb = (beat == nbeats - 1);
      if (beat == stall_beat && stalled < stall_cyc) begin
        rdy = 1'b0;
        stalled++;
      end else if (rand_rdy) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      s_if.rvalid = 1'b1;
      s_if.rdata  = data_q[beat];
      s_if.rresp  = resp_q[beat];
      s_if.rlast  = lastb;
      set_rready(owner, rdy);
      set_rready(other, 1'($urandom_range(0, 1)));
      if (lastb && rdy && req_last_m >= 0 && !pend_v[req_last_m])
        set_req(req_last_m, AW'($urandom), rand_ctl());
      @(negedge clock);
      check("data_state", dbg_state, 2);
      check("own_rvalid", get_rvalid(owner), 1);
      check("own_rdata", get_rdata(owner), data_q[beat]);
      check("own_rresp", get_rresp(owner), resp_q[beat]);
      check("own_rlast", get_rlast(owner), lastb);
      check("oth_rvalid", get_rvalid(other), 0);
      check("oth_rdata", get_rdata(other), 0);
      check("oth_rresp", get_rresp(other), 0);
      check("oth_rlast", get_rlast(other), 0);
      check("s_rready", s_if.rready, rdy);
      check("data_m0_arready", m0_if.arready, 0);
      check("data_m1_arready", m1_if.arready, 0);
      check("data_s_arvalid", s_if.arvalid, 0);
      if (rdy) check("sb_rdata", get_rdata(owner), exp_q.pop_front());
      @(posedge clock); #1;
      if (rdy) begin
        beat++;
        if (beat == abort_after) break;
      end
    end
    s_if.rvalid = 1'b0;
    s_if.rlast  = 1'b0;
    m0_if.rready = 1'b0;
    m1_if.rready = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clock);
    check("back_idle", dbg_state, 0);
    check("back_m0_arready", m0_if.arready, 0);
    check("back_m1_arready", m1_if.arready, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    int won;
    clear_inputs();

    // reset state, then a single IFU fetch
    do_reset();
    set_req(0, 32'h8000_0000, {8'd0, 3'd2, 2'd1});
    ar_phase(0, 0, won);
    data_q.delete(); resp_q.delete();
    data_q.push_back(32'h0000_0413); resp_q.push_back(2'd0);
    r_phase(won, 1, -1, 0, 0, -1, -1);
    idle_check();

    // both request after reset: grants alternate while both keep requesting
    do_reset();
    set_req(0, 32'h0000_1000, {8'd0, 3'd2, 2'd1});
    set_req(1, 32'h0000_2000, {8'd0, 3'd2, 2'd1});
    for (int i = 0; i < 4; i++) begin
      ar_phase(0, 0, won);
      set_req(won, AW'($urandom), {8'd0, 3'd2, 2'd1});
      fill_beats(1);
      r_phase(won, 1, -1, 0, 0, -1, -1);
    end
    clear_inputs();
    idle_check();

    // LSU burst of 4 with a 2-cycle rready stall on beat 2
    set_req(1, 32'h0000_3000, {8'd3, 3'd2, 2'd1});
    ar_phase(0, 0, won);
    data_q.delete(); resp_q.delete();
    data_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    resp_q = '{2'd0, 2'd0, 2'd0, 2'd0};
    r_phase(won, 4, 1, 2, 0, -1, -1);
    idle_check();

    // downstream AR accepted only after 5 wait cycles
    set_req(0, 32'hDEAD_BEE0, {8'd0, 3'd2, 2'd1});
    ar_phase(5, 0, won);
    fill_beats(1);
    r_phase(won, 1, -1, 0, 0, -1, -1);
    idle_check();

    // reset lands in DATA after beat 1 of 4; a fresh LSU request wins immediately
    set_req(0, 32'h0000_4000, {8'd3, 3'd2, 2'd1});
    ar_phase(0, 0, won);
    fill_beats(4);
    r_phase(won, 4, -1, 0, 0, -1, 1);
    reset = 1'b1;
    clear_inputs();
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    last_grant = 1;
    set_req(1, 32'h0000_5000, {8'd0, 3'd2, 2'd1});
    ar_phase(0, 1, won);
    fill_beats(1);
    r_phase(won, 1, -1, 0, 0, -1, -1);
    idle_check();

    // IFU requests again on its own rlast cycle
    set_req(0, 32'h0000_6000, {8'd1, 3'd2, 2'd1});
    ar_phase(0, 0, won);
    fill_beats(2);
    r_phase(won, 2, -1, 0, 0, 0, -1);
    ar_phase(0, 0, won);
    fill_beats(int'(granted_ctl[12:5]) + 1);
    r_phase(won, int'(granted_ctl[12:5]) + 1, -1, 0, 1, -1, -1);

    // randomized traffic
    for (int t = 0; t < 25; t++) begin
      int r;
      r = $urandom_range(1, 3);
      if ((r & 1) != 0 && !pend_v[0]) set_req(0, AW'($urandom), rand_ctl());
      if ((r & 2) != 0 && !pend_v[1]) set_req(1, AW'($urandom), rand_ctl());
      if (!pend_v[0] && !pend_v[1]) set_req(0, AW'($urandom), rand_ctl());
      ar_phase($urandom_range(0, 3), 0, won);
      fill_beats(int'(granted_ctl[12:5]) + 1);
      r_phase(won, int'(granted_ctl[12:5]) + 1, -1, 0, 1, $urandom_range(0, 2) - 1, -1);
    end
    clear_inputs();
    idle_check();
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
